// File: rtl/sdram_pkg.sv
// ============================================================================
// Module      : sdram_pkg
// Description : Shared SDRAM command encodings, arbiter state codes and
//               address-geometry constants for the controller datapaths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  typedef enum logic [3:0] {
    NOP      = 4'b0111,
    PRE      = 4'b0010,
    ACT      = 4'b0011,
    RD       = 4'b0101,
    WR       = 4'b0100,
    AREF_CMD = 4'b0001
  } sdram_cmd_e;

  typedef enum logic [4:0] {
    AREF  = 5'b00000,
    READ  = 5'b01000,
    WRITE = 5'b10000
  } arb_state_e;

  localparam int unsigned COL_END   = 508;
  localparam int unsigned ROW_END   = 4095;
  localparam int unsigned BURST_LEN = 4;

  localparam int unsigned COL_W = 9;
  localparam int unsigned ROW_W = 12;

endpackage

`default_nettype wire

// File: rtl/sdram_wr_burst_if.sv
// ============================================================================
// Module      : sdram_wr_burst_if
// Description : Arbiter, FIFO and SDRAM pin bundle of the write burst engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sdram_wr_burst_if;

  logic        wr_en;
  logic [4:0]  state;
  logic        ref_req;
  logic        key_wr;
  logic [15:0] wr_data;

  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_bank;
  logic [15:0] wr_dq;
  logic        wr_dq_oe;
  logic        wr_req;
  logic        flag_wr_end;
  logic        wr_data_req;

  modport master (
    input  wr_en, state, ref_req, key_wr, wr_data,
    output sdram_cmd, sdram_addr, sdram_bank, wr_dq, wr_dq_oe,
           wr_req, flag_wr_end, wr_data_req
  );

  modport slave (
    output wr_en, state, ref_req, key_wr, wr_data,
    input  sdram_cmd, sdram_addr, sdram_bank, wr_dq, wr_dq_oe,
           wr_req, flag_wr_end, wr_data_req
  );

endinterface

`default_nettype wire

// File: rtl/sdram_addr_ptr.sv
// ============================================================================
// Module      : sdram_addr_ptr
// Description : Linear row/column pointer stepping one burst group per
//               advance, wrapping column then row.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_addr_ptr
  import sdram_pkg::*;
#(
  parameter int unsigned COL_LAST = sdram_pkg::COL_END,
  parameter int unsigned ROW_LAST = sdram_pkg::ROW_END,
  parameter int unsigned STEP     = sdram_pkg::BURST_LEN
) (
  input  wire logic             sclk,
  input  wire logic             s_rst_n,
  input  wire logic             i_advance,
  output logic [ROW_W-1:0]      o_row,
  output logic [COL_W-1:0]      o_col
);

  localparam logic [COL_W-1:0] c_col_end = COL_W'(COL_LAST);
  localparam logic [ROW_W-1:0] c_row_end = ROW_W'(ROW_LAST);
  localparam logic [COL_W-1:0] c_step    = COL_W'(STEP);

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_advance) begin
      if (r_col == c_col_end) begin
        r_col <= '0;
        r_row <= (r_row == c_row_end) ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + c_step;
      end
    end
  end

  assign o_row = r_row;
  assign o_col = r_col;

endmodule

`default_nettype wire

// File: rtl/sdram_wr_burst.sv
// ============================================================================
// Module      : sdram_wr_burst
// Description : SDRAM write burst engine: PRE/ACT/WR sequencing, 4-word DQ
//               drive and linear write pointer while the arbiter is in WRITE.
//               Build option SDRAM_WR_PATTERN_EN replaces FIFO data with an
//               internal incrementing word counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_wr_burst
  import sdram_pkg::*;
#(
  parameter int unsigned CMD_END   = 12,
  parameter int unsigned COL_END   = sdram_pkg::COL_END,
  parameter int unsigned ROW_END   = sdram_pkg::ROW_END,
  parameter int unsigned BURST_LEN = sdram_pkg::BURST_LEN
) (
  input  wire logic           sclk,
  input  wire logic           s_rst_n,
  sdram_wr_burst_if.master    bus
);

  localparam logic [3:0] c_cnt_pre  = 4'd2;
  localparam logic [3:0] c_cnt_act  = 4'd3;
  localparam logic [3:0] c_cnt_wr   = 4'd4;
  localparam logic [3:0] c_req_last = 4'(3 + BURST_LEN - 1);
  localparam logic [3:0] c_dq_last  = 4'(4 + BURST_LEN - 1);
  localparam logic [3:0] c_cmd_end  = 4'(CMD_END);

  logic [3:0]       r_cmd_cnt;
  logic             r_flag_act;
  logic [3:0]       r_sdram_cmd;
  logic [11:0]      r_sdram_addr;
  logic [15:0]      r_wr_dq;
  logic             r_wr_dq_oe;
  logic             r_wr_req;
  logic             r_flag_wr_end;
  logic             r_wr_data_req;

  logic             w_in_write;
  logic [ROW_W-1:0] w_row;
  logic [COL_W-1:0] w_col;
  logic             w_col_zero;
  logic [3:0]       w_cmd_nxt;
  logic [11:0]      w_addr_nxt;
  logic             w_req_nxt;
  logic             w_oe_nxt;
  logic [15:0]      w_dq_src;

  assign w_in_write = (bus.state == WRITE);
  assign w_col_zero = (w_col == '0);

  sdram_addr_ptr #(
    .COL_LAST (COL_END),
    .ROW_LAST (ROW_END),
    .STEP     (BURST_LEN)
  ) u_ptr (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .i_advance (r_flag_wr_end),
    .o_row     (w_row),
    .o_col     (w_col)
  );

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_cmd_cnt <= '0;
    end else if (w_in_write) begin
      r_cmd_cnt <= r_cmd_cnt + 4'd1;
    end else begin
      r_cmd_cnt <= '0;
    end
  end

  // Slot decode is gated by WRITE so an aborted burst stops driving at once.
  always_comb begin
    w_cmd_nxt  = NOP;
    w_addr_nxt = w_row;
    w_req_nxt  = 1'b0;
    w_oe_nxt   = 1'b0;
    if (w_in_write) begin
      case (r_cmd_cnt)
        c_cnt_pre: if (w_col_zero) w_cmd_nxt = PRE;
        c_cnt_act: if (r_flag_act || w_col_zero) w_cmd_nxt = ACT;
        c_cnt_wr: begin
          w_cmd_nxt  = WR;
          w_addr_nxt = {3'b000, w_col};
        end
        default: w_cmd_nxt = NOP;
      endcase
      w_req_nxt = (r_cmd_cnt >= c_cnt_act) && (r_cmd_cnt <= c_req_last);
      w_oe_nxt  = (r_cmd_cnt >= c_cnt_wr)  && (r_cmd_cnt <= c_dq_last);
    end
  end

`ifdef SDRAM_WR_PATTERN_EN
  logic [15:0] r_pat;
  logic        w_unused_wr_data;

  assign w_unused_wr_data = ^bus.wr_data;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_pat <= '0;
    end else if (w_oe_nxt) begin
      r_pat <= r_pat + 16'd1;
    end
  end

  assign w_dq_src = r_pat;
`else
  assign w_dq_src = bus.wr_data;
`endif

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_sdram_cmd   <= NOP;
      r_sdram_addr  <= '0;
      r_wr_dq       <= '0;
      r_wr_dq_oe    <= 1'b0;
      r_wr_req      <= 1'b0;
      r_flag_wr_end <= 1'b0;
      r_wr_data_req <= 1'b0;
      r_flag_act    <= 1'b0;
    end else begin
      r_sdram_cmd   <= w_cmd_nxt;
      r_sdram_addr  <= w_addr_nxt;
      r_wr_data_req <= w_req_nxt;
      r_wr_dq_oe    <= w_oe_nxt;
      if (w_oe_nxt) begin
        r_wr_dq <= w_dq_src;
      end
      r_flag_wr_end <= (r_cmd_cnt == c_cmd_end);
      if (bus.wr_en) begin
        r_wr_req <= 1'b0;
      end else if (bus.key_wr && !w_in_write) begin
        r_wr_req <= 1'b1;
      end
      // A refresh during this slot closes the row, so the next burst re-ACTs.
      if (r_flag_wr_end) begin
        r_flag_act <= bus.ref_req;
      end
    end
  end

  assign bus.sdram_cmd   = r_sdram_cmd;
  assign bus.sdram_addr  = r_sdram_addr;
  assign bus.sdram_bank  = 2'b00;
  assign bus.wr_dq       = r_wr_dq;
  assign bus.wr_dq_oe    = r_wr_dq_oe;
  assign bus.wr_req      = r_wr_req;
  assign bus.flag_wr_end = r_flag_wr_end;
  assign bus.wr_data_req = r_wr_data_req;

endmodule

`default_nettype wire
